// File: rtl/uart_tx.sv
// UART transmitter: takes one byte per frame from a valid/ready source and
// sends start, LSB-first data, optional parity and 1-2 stop bits on txd.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_valid,
    input  logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_ready,
    output logic                  txd,
    output logic                  busy
);
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [BCW-1:0]       BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic                 ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  bit_tick;

    assign bit_tick = (div_cnt == DIV_LAST);
    assign m_ready  = (state == S_IDLE) && !reset;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    txd     <= 1'b1;
                    if (m_valid) begin
                        // Parity comes from the captured byte, so later m_data churn cannot leak in.
                        shreg   <= m_data;
                        par_bit <= (^m_data) ^ ODD;
                        txd     <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        txd     <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        div_cnt <= '0;
                        shreg   <= shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY != 0) begin
                                txd   <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                txd      <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                            txd     <= shreg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        div_cnt  <= '0;
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= S_STOP;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    txd <= 1'b1;
                    if (bit_tick) begin
                        div_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five configurations side by side, checked against a
// frame-level line model and a mid-bit sampling receiver.
module tb_uart_tx;
    localparam int NI = 5;
    localparam int CDS  [NI] = '{4, 4, 4, 4, 3};
    localparam int PARS [NI] = '{0, 2, 1, 0, 1};
    localparam int SBS  [NI] = '{1, 1, 1, 2, 2};

    logic          clk;
    logic          reset;
    logic [NI-1:0] mv, mr, tx, bz;
    logic [7:0]    md [NI];

    int total, bad;

    logic cap_tx [0:255];
    logic cap_bz [0:255];
    logic cap_mr [0:255];
    logic exp_bit [0:15];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .DATA_WIDTH(8), .CLK_DIV(CDS[g]), .DIV_WIDTH(16),
            .PARITY(PARS[g]), .STOP_BITS(SBS[g])
        ) dut (
            .clk(clk), .reset(reset), .m_valid(mv[g]), .m_data(md[g]),
            .m_ready(mr[g]), .txd(tx[g]), .busy(bz[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line model: the list of bit levels making up one frame for instance k.
    function automatic int build_frame(input int k, input logic [7:0] b);
        int n;
        n = 0;
        exp_bit[n] = 1'b0; n = n + 1;
        for (int i = 0; i < 8; i++) begin exp_bit[n] = b[i]; n = n + 1; end
        if (PARS[k] != 0) begin
            // even: total ones incl. parity even; odd: total ones odd
            exp_bit[n] = (($countones(b) % 2) == 1) ^ (PARS[k] == 1);
            n = n + 1;
        end
        for (int s = 0; s < SBS[k]; s++) begin exp_bit[n] = 1'b1; n = n + 1; end
        return n;
    endfunction

    task automatic start_byte(input int k, input logic [7:0] b);
        @(negedge clk);
        md[k] = b;
        mv[k] = 1'b1;
        @(posedge clk);
        #1;
        mv[k] = 1'b0;
    endtask

    task automatic capture(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i] = tx[k];
            cap_bz[i] = bz[k];
            cap_mr[i] = mr[k];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mv = '0;
        for (int k = 0; k < NI; k++) md[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total++; if (tx[k] !== 1'b1) begin bad++; $display("FAIL reset_txd[%0d] got=%b want=1", k, tx[k]); end
            total++; if (bz[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", k, bz[k]); end
            total++; if (mr[k] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b want=0", k, mr[k]); end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total++; if (mr[k] !== 1'b1) begin bad++; $display("FAIL post_reset_ready[%0d] got=%b want=1", k, mr[k]); end
        end
        // no valid: line must stay idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (tx[0] !== 1'b1 || bz[0] !== 1'b0) begin
                bad++; $display("FAIL idle_hold[%0d] txd=%b busy=%b want txd=1 busy=0", i, tx[0], bz[0]);
            end
        end
    endtask

    task automatic test_basic();
        int n;
        n = build_frame(0, 8'hA5);
        start_byte(0, 8'hA5);
        capture(0, n * 4 + 1);
        for (int i = 0; i < n * 4; i++) begin
            total++; if (cap_tx[i] !== exp_bit[i / 4]) begin bad++; $display("FAIL basic_txd[%0d] got=%b want=%b", i, cap_tx[i], exp_bit[i / 4]); end
            total++; if (cap_bz[i] !== 1'b1) begin bad++; $display("FAIL basic_busy[%0d] got=%b want=1", i, cap_bz[i]); end
            total++; if (cap_mr[i] !== 1'b0) begin bad++; $display("FAIL basic_ready[%0d] got=%b want=0", i, cap_mr[i]); end
        end
        total++; if (cap_tx[n*4] !== 1'b1 || cap_bz[n*4] !== 1'b0 || cap_mr[n*4] !== 1'b1) begin
            bad++; $display("FAIL basic_end txd=%b busy=%b ready=%b want 1/0/1", cap_tx[n*4], cap_bz[n*4], cap_mr[n*4]);
        end
    endtask

    task automatic test_parity();
        int          ks [3];
        logic [7:0]  bs [3];
        logic        pe [3];
        int          n;
        ks[0] = 1; bs[0] = 8'hA5; pe[0] = 1'b0;
        ks[1] = 2; bs[1] = 8'hA5; pe[1] = 1'b1;
        ks[2] = 2; bs[2] = 8'h01; pe[2] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            n = build_frame(ks[t], bs[t]);
            start_byte(ks[t], bs[t]);
            capture(ks[t], n * 4 + 1);
            for (int i = 0; i < n * 4; i++) begin
                total++; if (cap_tx[i] !== exp_bit[i / 4]) begin
                    bad++; $display("FAIL parity_txd[t%0d,%0d] got=%b want=%b", t, i, cap_tx[i], exp_bit[i / 4]);
                end
            end
            total++; if (cap_tx[37] !== pe[t]) begin bad++; $display("FAIL parity_bit[t%0d] got=%b want=%b", t, cap_tx[37], pe[t]); end
            total++; if (cap_bz[n*4] !== 1'b0) begin bad++; $display("FAIL parity_len[t%0d] busy=%b want=0", t, cap_bz[n*4]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [3];
        logic       ew [0:135];
        int         acc_at [3];
        int         nacc, nxt, n;
        q[0] = 8'h00; q[1] = 8'hFF; q[2] = 8'h55;
        nacc = 0; nxt = 0;
        ew[0] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            n = build_frame(3, q[f]);
            for (int i = 0; i < n * 4; i++) ew[1 + 45*f + i] = exp_bit[i / 4];
            ew[45 + 45*f] = 1'b1;
        end
        @(negedge clk);
        md[3] = q[0];
        mv[3] = 1'b1;
        for (int i = 0; i < 136; i++) begin
            cap_tx[i] = tx[3];
            if (mr[3] && mv[3]) begin
                if (nacc < 3) acc_at[nacc] = i;
                nacc++;
                @(posedge clk);
                #1;
                nxt++;
                if (nxt < 3) md[3] = q[nxt]; else mv[3] = 1'b0;
            end
            @(negedge clk);
        end
        mv[3] = 1'b0;
        total++; if (nacc !== 3) begin bad++; $display("FAIL stream_accepts got=%0d want=3", nacc); end
        for (int f = 0; f < 3 && f < nacc; f++) begin
            total++; if (acc_at[f] !== 45 * f) begin bad++; $display("FAIL stream_accept_cycle[%0d] got=%0d want=%0d", f, acc_at[f], 45 * f); end
        end
        for (int i = 0; i < 136; i++) begin
            total++; if (cap_tx[i] !== ew[i]) begin bad++; $display("FAIL stream_txd[%0d] got=%b want=%b", i, cap_tx[i], ew[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start_byte(0, 8'h3C);
        capture(0, 18);
        total++; if (cap_tx[17] !== 1'b1 || cap_bz[17] !== 1'b1) begin
            bad++; $display("FAIL rmid_bit3 txd=%b busy=%b want 1/1", cap_tx[17], cap_bz[17]);
        end
        reset = 1'b1;
        @(negedge clk);
        total++; if (tx[0] !== 1'b1) begin bad++; $display("FAIL rmid_txd got=%b want=1", tx[0]); end
        total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bz[0]); end
        total++; if (mr[0] !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_reset got=%b want=0", mr[0]); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (mr[0] !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%b want=1", mr[0]); end
        n = build_frame(0, 8'hC3);
        start_byte(0, 8'hC3);
        capture(0, n * 4 + 1);
        for (int i = 0; i < n * 4 + 1; i++) begin
            logic e;
            e = (i < n * 4) ? exp_bit[i / 4] : 1'b1;
            total++; if (cap_tx[i] !== e) begin bad++; $display("FAIL rmid_next_txd[%0d] got=%b want=%b", i, cap_tx[i], e); end
        end
    endtask

    task automatic test_stability();
        int n;
        n = build_frame(0, 8'h96);
        start_byte(0, 8'h96);
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            cap_tx[i] = tx[0];
            cap_bz[i] = bz[0];
            md[0] = 8'($urandom);
            mv[0] = (i < 38) ? 1'($urandom) : 1'b0;
        end
        mv[0] = 1'b0;
        for (int i = 0; i < n * 4; i++) begin
            total++; if (cap_tx[i] !== exp_bit[i / 4]) begin bad++; $display("FAIL stable_txd[%0d] got=%b want=%b", i, cap_tx[i], exp_bit[i / 4]); end
        end
        total++; if (cap_bz[40] !== 1'b0 || cap_bz[41] !== 1'b0 || cap_tx[41] !== 1'b1) begin
            bad++; $display("FAIL stable_no_extra busy40=%b busy41=%b txd41=%b want 0/0/1", cap_bz[40], cap_bz[41], cap_tx[41]);
        end
    endtask

    task automatic test_random();
        logic [7:0] sent [$];
        int         rx_cnt;
        rx_cnt = 0;
        fork
            begin : drv
                for (int i = 0; i < 200; i++) begin
                    int n;
                    @(negedge clk);
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    md[4] = 8'($urandom);
                    mv[4] = 1'b1;
                    sent.push_back(md[4]);
                    n = 0;
                    while (!mr[4] && n < 200) begin @(negedge clk); n++; end
                    if (!mr[4]) begin
                        total++; bad++;
                        $display("FAIL rand_accept_timeout[%0d] ready=%b want=1", i, mr[4]);
                        mv[4] = 1'b0;
                        break;
                    end
                    @(posedge clk);
                    #1;
                    mv[4] = 1'b0;
                end
            end
            begin : rcv
                for (int j = 0; j < 200; j++) begin
                    int         n;
                    logic [7:0] d, e;
                    logic       p;
                    n = 0;
                    @(negedge clk);
                    while (tx[4] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
                    if (tx[4] !== 1'b0) begin
                        total++; bad++;
                        $display("FAIL rand_start_timeout[%0d] txd=%b want=0", j, tx[4]);
                        break;
                    end
                    @(negedge clk);
                    total++; if (tx[4] !== 1'b0) begin bad++; $display("FAIL rand_start_mid[%0d] got=%b want=0", j, tx[4]); end
                    for (int b = 0; b < 8; b++) begin repeat (3) @(negedge clk); d[b] = tx[4]; end
                    repeat (3) @(negedge clk);
                    p = tx[4];
                    for (int s = 0; s < 2; s++) begin
                        repeat (3) @(negedge clk);
                        total++; if (tx[4] !== 1'b1) begin bad++; $display("FAIL rand_stop[%0d,%0d] got=%b want=1", j, s, tx[4]); end
                    end
                    e = (sent.size() > 0) ? sent.pop_front() : 8'hxx;
                    total++; if (d !== e) begin bad++; $display("FAIL rand_data[%0d] got=%h want=%h", j, d, e); end
                    total++; if (($countones({d, p}) % 2) != 1) begin bad++; $display("FAIL rand_parity[%0d] data=%h par=%b want odd total", j, d, p); end
                    rx_cnt++;
                end
            end
        join
        total++; if (rx_cnt != 200 || sent.size() != 0) begin
            bad++; $display("FAIL rand_count got=%0d left=%0d want 200/0", rx_cnt, sent.size());
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
